// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler
// Splits each data-island period into fixed-length packet slots and assigns
// every slot either to the highest-priority pending packet source or to a
// NULL packet. Pending bits come from per-frame enables (vsync rising edge)
// and from one-shot requests. Overrun and truncated-island conditions are
// latched as sticky error flags until err_clr.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no slot in progress; waiting for data_island to rise
//   SLOT  | slot in progress; slot_phase counts 0 .. SLOT_LEN-1
//
// A slot decision (arbitration) happens either on the first data_island
// cycle seen in IDLE, or at the last phase of a slot while data_island is
// still high, so back-to-back slots have no gap.

module hdmi_packet_scheduler #(
  parameter int NSRC     = 4,
  parameter int SLOT_LEN = 32,
  localparam int PW      = $clog2(SLOT_LEN),
  localparam int SW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vsync,
  input  logic            data_island,
  input  logic [NSRC-1:0] src_en,
  input  logic [NSRC-1:0] src_req,
  input  logic            err_clr,
  output logic            slot_active,
  output logic            slot_start,
  output logic [PW-1:0]   slot_phase,
  output logic [SW-1:0]   pkt_sel,
  output logic            pkt_null,
  output logic [NSRC-1:0] src_ack,
  output logic [NSRC-1:0] overrun,
  output logic            island_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_LEN - 1);

  state_t          state;
  logic [NSRC-1:0] pend;
  logic            vsync_d;

  logic            vsync_rise;
  logic            last_phase;
  logic            arb;
  logic            truncate;
  logic            found;
  logic [SW-1:0]   win_idx;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] pend_set;
  logic [NSRC-1:0] ovr_set;

  // Decode frame edge, slot boundary and island truncation for this cycle.
  always_comb begin
    vsync_rise = vsync & ~vsync_d;
    last_phase = (slot_phase == LAST_PHASE);
    arb        = 1'b0;
    truncate   = 1'b0;
    if (state == IDLE) begin
      arb = data_island;
    end else begin
      arb      = data_island & last_phase;
      truncate = ~data_island & ~last_phase;
    end
  end

  // Lowest-index pending source wins; scan from the top so index 0 overrides.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        found   = 1'b1;
        win_idx = SW'(i);
      end
    end
  end

  // Grant vector plus the set terms that feed pend and overrun.
  always_comb begin
    grant = '0;
    if (arb && found) begin
      grant = NSRC'(1) << win_idx;
    end
    pend_set = src_req | (vsync_rise ? src_en : '0);
    // A source being granted right at the frame edge is being served, so it
    // is not counted as an overrun.
    ovr_set  = vsync_rise ? (pend & ~grant) : '0;
  end

  // Slot sequencing FSM with registered slot/arbitration outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot_active <= 1'b0;
      slot_start  <= 1'b0;
      slot_phase  <= '0;
      pkt_sel     <= '0;
      pkt_null    <= 1'b0;
      src_ack     <= '0;
    end else begin
      slot_start <= 1'b0;
      src_ack    <= '0;
      if (arb) begin
        state       <= SLOT;
        slot_active <= 1'b1;
        slot_start  <= 1'b1;
        slot_phase  <= '0;
        pkt_null    <= ~found;
        pkt_sel     <= found ? win_idx : '0;
        src_ack     <= grant;
      end else if (state == SLOT && data_island) begin
        slot_phase <= slot_phase + PW'(1);
      end else begin
        // Covers the normal end of an island and an aborted slot alike.
        state       <= IDLE;
        slot_active <= 1'b0;
        slot_phase  <= '0;
        pkt_sel     <= '0;
        pkt_null    <= 1'b0;
      end
    end
  end

  // Pending bits, vsync history and sticky error flags. Sets beat clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      vsync_d    <= 1'b1;
      overrun    <= '0;
      island_err <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      pend       <= (pend & ~grant) | pend_set;
      overrun    <= (err_clr ? '0 : overrun) | ovr_set;
      island_err <= (island_err & ~err_clr) | truncate;
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler: single slot, multi-slot island,
// truncated island, overrun / set-wins and reset in the middle of a slot.

module tb_hdmi_packet_scheduler;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       data_island;
  logic [3:0] src_en;
  logic [3:0] src_req;
  logic       err_clr;
  logic       slot_active;
  logic       slot_start;
  logic [4:0] slot_phase;
  logic [1:0] pkt_sel;
  logic       pkt_null;
  logic [3:0] src_ack;
  logic [3:0] overrun;
  logic       island_err;

  int checks;
  int failures;

  hdmi_packet_scheduler #(
    .NSRC     (4),
    .SLOT_LEN (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .data_island (data_island),
    .src_en      (src_en),
    .src_req     (src_req),
    .err_clr     (err_clr),
    .slot_active (slot_active),
    .slot_start  (slot_start),
    .slot_phase  (slot_phase),
    .pkt_sel     (pkt_sel),
    .pkt_null    (pkt_null),
    .src_ack     (src_ack),
    .overrun     (overrun),
    .island_err  (island_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " slot_active"}, 32'(slot_active), 32'd0);
    check({tag, " slot_start"},  32'(slot_start),  32'd0);
    check({tag, " slot_phase"},  32'(slot_phase),  32'd0);
    check({tag, " pkt_sel"},     32'(pkt_sel),     32'd0);
    check({tag, " pkt_null"},    32'(pkt_null),    32'd0);
    check({tag, " src_ack"},     32'(src_ack),     32'd0);
  endtask

  logic [1:0] exp_sel  [4];
  logic       exp_null [4];
  logic [3:0] exp_ack  [4];

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    vsync       = 1'b0;
    data_island = 1'b0;
    src_en      = 4'b0000;
    src_req     = 4'b0000;
    err_clr     = 1'b0;
    exp_sel     = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_null    = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_ack     = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset overrun",    32'(overrun),    32'd0);
    check("reset island_err", 32'(island_err), 32'd0);
    check("reset pend",       32'(dut.pend),   32'd0);

    // 1. Single slot
    reset  = 1'b0;
    src_en = 4'b0101;
    tick();
    vsync = 1'b1;
    tick();
    check("t1 pend after vsync", 32'(dut.pend), 32'b0101);
    vsync = 1'b0;
    tick();
    data_island = 1'b1;
    tick();
    check("t1 slot_start",  32'(slot_start),  32'd1);
    check("t1 slot_active", 32'(slot_active), 32'd1);
    check("t1 phase0",      32'(slot_phase),  32'd0);
    check("t1 pkt_sel",     32'(pkt_sel),     32'd0);
    check("t1 pkt_null",    32'(pkt_null),    32'd0);
    check("t1 src_ack",     32'(src_ack),     32'b0001);
    for (int k = 2; k <= 32; k++) tick();
    check("t1 phase31",       32'(slot_phase),  32'd31);
    check("t1 ack gone",      32'(src_ack),     32'd0);
    check("t1 start gone",    32'(slot_start),  32'd0);
    check("t1 active at 31",  32'(slot_active), 32'd1);
    data_island = 1'b0;
    tick();
    check("t1 active after",  32'(slot_active), 32'd0);
    check("t1 pend after",    32'(dut.pend),    32'b0100);
    check("t1 no island_err", 32'(island_err),  32'd0);

    // 2. Multi-slot island
    src_req = 4'b1010;
    tick();
    src_req = 4'b0000;
    check("t2 pend", 32'(dut.pend), 32'b1110);
    data_island = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      check("t2 phase",  32'(slot_phase),  32'((k - 1) % 32));
      check("t2 start",  32'(slot_start),  32'(((k - 1) % 32) == 0));
      check("t2 active", 32'(slot_active), 32'd1);
      check("t2 sel",    32'(pkt_sel),     32'(exp_sel[(k - 1) / 32]));
      check("t2 null",   32'(pkt_null),    32'(exp_null[(k - 1) / 32]));
      check("t2 ack",    32'(src_ack),
            (((k - 1) % 32) == 0) ? 32'(exp_ack[(k - 1) / 32]) : 32'd0);
    end
    data_island = 1'b0;
    tick();
    check("t2 active after", 32'(slot_active), 32'd0);
    check("t2 pend after",   32'(dut.pend),    32'd0);

    // 3. Truncated island
    src_req = 4'b0001;
    tick();
    src_req = 4'b0000;
    data_island = 1'b1;
    tick();
    check("t3 ack", 32'(src_ack), 32'b0001);
    for (int k = 2; k <= 20; k++) tick();
    check("t3 phase19", 32'(slot_phase), 32'd19);
    check("t3 no err yet", 32'(island_err), 32'd0);
    data_island = 1'b0;
    tick();
    check("t3 active", 32'(slot_active), 32'd0);
    check("t3 island_err", 32'(island_err), 32'd1);
    check("t3 not repended", 32'(dut.pend), 32'd0);
    tick();
    check("t3 err sticky", 32'(island_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3 err cleared", 32'(island_err), 32'd0);

    // 4. Overrun and set-wins
    src_en = 4'b0010;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    check("t4 pend edge1",    32'(dut.pend), 32'b0010);
    check("t4 overrun edge1", 32'(overrun),  32'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    check("t4 overrun edge2", 32'(overrun), 32'b0010);
    data_island = 1'b1;
    src_req     = 4'b0010;
    tick();
    src_req = 4'b0000;
    check("t4 ack",      32'(src_ack),  32'b0010);
    check("t4 set wins", 32'(dut.pend), 32'b0010);
    for (int k = 2; k <= 33; k++) tick();
    check("t4 second start", 32'(slot_start), 32'd1);
    check("t4 second ack",   32'(src_ack),    32'b0010);
    check("t4 second sel",   32'(pkt_sel),    32'd1);
    for (int k = 34; k <= 64; k++) tick();
    data_island = 1'b0;
    tick();
    check("t4 pend drained",  32'(dut.pend), 32'd0);
    check("t4 overrun stays", 32'(overrun),  32'b0010);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4 overrun cleared", 32'(overrun), 32'd0);

    // 5. Reset mid-slot
    src_req = 4'b1111;
    tick();
    src_req = 4'b0000;
    check("t5 pend all", 32'(dut.pend), 32'b1111);
    data_island = 1'b1;
    for (int k = 1; k <= 11; k++) tick();
    check("t5 phase10", 32'(slot_phase), 32'd10);
    reset = 1'b1;
    vsync = 1'b1;
    tick();
    check_idle_outputs("t5 reset");
    check("t5 overrun",    32'(overrun),    32'd0);
    check("t5 island_err", 32'(island_err), 32'd0);
    check("t5 pend",       32'(dut.pend),   32'd0);
    reset       = 1'b0;
    data_island = 1'b0;
    tick();
    tick();
    tick();
    check("t5 no spurious edge", 32'(dut.pend), 32'd0);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    check("t5 real edge", 32'(dut.pend), 32'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_packet_scheduler.md
# hdmi_packet_scheduler

Schedules HDMI data-island packet slots on the `hdmi_clk` domain. It sits between the 800x480 sync generator and the video encoder's data-island path. Each data-island period from the sync generator is split into 32-cycle packet slots. Up to NSRC packet sources (AVI InfoFrame, audio InfoFrame, ACR, vendor) are arbitrated into those slots, and a NULL packet fills any slot with no pending source.

## Interface
Parameters:
- NSRC, 4: number of packet sources; index 0 has the highest priority.
- SLOT_LEN, 32: cycles per packet slot; must be a power of two.

Ports:
- clk, in, 1: `hdmi_clk` pixel clock.
- reset, in, 1: synchronous, active-high.
- vsync, in, 1: active-high vsync from the sync generator.
- data_island, in, 1: high during data-island periods; a period's length is nominally a multiple of SLOT_LEN.
- src_en, in, NSRC: per-source enable; an enabled source becomes pending once per frame.
- src_req, in, NSRC: one-cycle pulses; each makes that source pending immediately.
- err_clr, in, 1: clears the sticky error flags.
- slot_active, out, 1: a packet slot is in progress.
- slot_start, out, 1: one-cycle pulse on slot phase 0.
- slot_phase, out, log2(SLOT_LEN): cycle index within the current slot.
- pkt_sel, out, max(1,clog2(NSRC)): granted source index; valid while slot_active.
- pkt_null, out, 1: the current slot carries a NULL packet.
- src_ack, out, NSRC: one-hot, one-cycle pulse to the granted source, coincident with slot_start.
- overrun, out, NSRC: sticky; the source was still pending at the next frame edge.
- island_err, out, 1: sticky; a data-island period ended mid-slot.

## Operation
- **Pending bits:** `pend[NSRC]`.
  - Set by a vsync rising edge (for src_en bits) or by src_req.
  - Cleared by a grant.
  - If a set and a grant of the same bit occur in the same cycle, the set wins and the bit stays pending.
- **Vsync edge detect:** rising edge is `vsync & ~vsync_d`. `vsync_d` resets to 1, so no spurious edge occurs when leaving reset.
- **Arbitration:** at each slot start, grant the lowest-index pending source.
  - If one is found: pkt_sel = its index, pkt_null = 0, src_ack bit pulses.
  - If none is pending: pkt_null = 1, pkt_sel = 0, no ack.
- **State machine, IDLE → SLOT:**
  - IDLE: when data_island = 1, enter SLOT at phase 0 and arbitrate.
  - SLOT: phase increments each cycle.
  - At phase SLOT_LEN-1 with data_island still 1: wrap to phase 0, arbitrate again, pulse slot_start.
  - At phase SLOT_LEN-1 with data_island = 0: return to IDLE.
- **Truncated island:** if data_island drops while in SLOT at any phase other than SLOT_LEN-1:
  - abort the slot and go to IDLE;
  - set island_err;
  - the granted source is not re-pended.
- **Overrun:** on a vsync rising edge, overrun[i] is set when pend[i] = 1 and source i is not being granted in that cycle.
- **Error clear:** err_clr clears overrun and island_err. A new error in the same cycle as err_clr wins.
- **Reset values:** every output, all pend bits and the state (IDLE) reset to 0; `vsync_d` resets to 1.

## Timing
- All outputs are registered.
- The first data_island = 1 seen at cycle t produces slot_start, slot_active, phase 0 and the src_ack pulse at cycle t+1.
- data_island = 0 at cycle t with phase ≠ SLOT_LEN-1: slot_active is 0 at t+1 and island_err is 1 at t+1.
- Arbitration samples pend as it stands in the cycle of the decision.
  - A src_req arriving in that cycle is not visible until the next slot.
  - A vsync-edge set in that cycle is likewise deferred.
- pkt_sel and pkt_null are held constant for all SLOT_LEN cycles of a slot.
- Back-to-back slots: phase SLOT_LEN-1 is followed directly by phase 0; slot_active has no gap.
- A source is granted at most once per pending assertion. A re-request made during its own slot becomes pending and may win the next slot.

## Test plan
1. **Single slot:** reset; src_en = 4'b0101; vsync pulse; data_island high for 32 cycles.
   - slot_start is 1 cycle after data_island.
   - pkt_sel = 0 and src_ack = 4'b0001.
   - pend = 4'b0100 afterwards.
   - slot_active low after phase 31.
2. **Multi-slot island:** pend = 4'b1110; data_island high for 128 cycles.
   - Four slots with pkt_sel = 1, 2, 3, then pkt_null = 1.
   - slot_start pulses exactly every 32 cycles.
3. **Truncated island:** data_island high for 20 cycles.
   - Slot aborts at phase 19.
   - island_err = 1 on the cycle after the drop.
   - The granted source is not re-pended.
   - err_clr clears island_err.
4. **Overrun and set-wins:**
   - src_en = 4'b0010 with no islands across two vsync edges → overrun = 4'b0010.
   - src_req[1] in the same cycle as the grant of source 1 → pend[1] stays 1.
5. **Reset mid-slot:** assert reset at phase 10 with pend = 4'b1111.
   - All outputs and pend are 0 the next cycle.
   - vsync held high after reset produces no pending set until it falls and rises again.
